// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin arbiter with burst lock, sharing one synchronous sprite ROM
module sprite_rom_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned DEPTH     = 80000,
    parameter int unsigned BURST_MAX = 8
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [DATA_W-1:0]       rom_data,
    output logic [N_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_err
);
    localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned BCNT_W = $clog2(BURST_MAX + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [N_REQ-1:0]    valid_q, valid_d;
    logic                err_q, err_d;

    logic                owner_req;
    logic                others_req;
    logic                burst_out;
    logic                lock_hit;
    logic [IDX_W-1:0]    start_idx;
    logic                win_any;
    logic [IDX_W-1:0]    win_idx;
    logic [ADDR_W-1:0]   sel_addr;
    int unsigned         cand;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (32'(i) >= N_REQ - 1) return '0;
        return i + IDX_W'(1);
    endfunction

    // Winner selection: keep the owner while its burst lasts, otherwise round-robin search
    always_comb begin
        owner_req  = (state_q == ST_OWNED) && req[owner_q];
        others_req = |(req & ~(N_REQ'(1) << owner_q));
        burst_out  = (bcnt_q >= BCNT_W'(BURST_MAX)) && others_req;
        lock_hit   = owner_req && !burst_out;
        start_idx  = owner_req ? next_idx(owner_q) : ptr_q;
        win_any    = 1'b0;
        win_idx    = '0;
        cand       = 0;
        if (lock_hit) begin
            win_any = 1'b1;
            win_idx = owner_q;
        end else begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                cand = 32'(start_idx) + k;
                if (cand >= N_REQ) cand = cand - N_REQ;
                if (!win_any && req[IDX_W'(cand)]) begin
                    win_any = 1'b1;
                    win_idx = IDX_W'(cand);
                end
            end
        end
        if (Reset) begin
            win_any = 1'b0;
            win_idx = '0;
        end
    end

    // One-hot grant and the ROM address mux (holds the last address when idle)
    always_comb begin
        gnt      = '0;
        sel_addr = '0;
        if (win_any) gnt = N_REQ'(1) << win_idx;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win_idx == IDX_W'(i)) sel_addr = addr[i*ADDR_W +: ADDR_W];
        end
        rom_addr   = win_any ? sel_addr : rom_addr_q;
        rom_addr_d = rom_addr;
    end

    // Ownership, pointer and burst-count next state
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;
        if (win_any) begin
            state_d = ST_OWNED;
            owner_d = win_idx;
            ptr_d   = next_idx(win_idx);
            if (lock_hit) begin
                // saturate: once at the limit, any other request breaks the lock
                bcnt_d = (bcnt_q >= BCNT_W'(BURST_MAX)) ? bcnt_q : bcnt_q + BCNT_W'(1);
            end else begin
                bcnt_d = BCNT_W'(1);
            end
        end else if (req == '0) begin
            state_d = ST_IDLE;
        end
    end

    // Read tag and range flag travel alongside the ROM's one-cycle latency
    always_comb begin
        valid_d = gnt;
        err_d   = win_any && (64'(sel_addr) >= 64'(DEPTH));
    end

    // State registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            bcnt_q     <= '0;
            rom_addr_q <= '0;
            valid_q    <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            bcnt_q     <= bcnt_d;
            rom_addr_q <= rom_addr_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    // A read returning while Reset is high is dropped; out-of-range reads return zero
    assign rd_valid = valid_q & {N_REQ{~Reset}};
    assign rd_err   = err_q & ~Reset;
    assign rd_data  = ((|rd_valid) && !rd_err) ? rom_data : '0;

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 The module SHALL have parameter N_REQ, default 4, giving the number of requesters sharing one sprite ROM.
REQ-002 The module SHALL have parameter ADDR_W, default 17, giving the ROM address width.
REQ-003 The module SHALL have parameter DATA_W, default 4, giving the ROM palette-index width.
REQ-004 The module SHALL have parameter DEPTH, default 80000, giving the number of valid ROM words.
REQ-005 The module SHALL have parameter BURST_MAX, default 8, giving the maximum consecutive grants to one requester while others wait.
REQ-006 The module SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The module SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The module SHALL have port req, input, N_REQ bits: per-requester read request, bit i for requester i.
REQ-009 The module SHALL have port addr, input, N_REQ*ADDR_W bits: requester i address in bits [i*ADDR_W +: ADDR_W].
REQ-010 The module SHALL have port gnt, output, N_REQ bits: one-hot or zero, combinational; accepts that requester's address this cycle.
REQ-011 The module SHALL have port rom_addr, output, ADDR_W bits: address to the synchronous ROM (1-cycle read latency).
REQ-012 The module SHALL have port rom_data, input, DATA_W bits: ROM read data, valid the cycle after the address edge.
REQ-013 The module SHALL have port rd_valid, output, N_REQ bits: one-hot or zero; marks rd_data as belonging to requester i.
REQ-014 The module SHALL have port rd_data, output, DATA_W bits: returned pixel data.
REQ-015 The module SHALL have port rd_err, output, 1 bit: high with rd_valid when the returned read was out of range.

Function
REQ-016 Handshake: a request SHALL complete in cycle T when req[i]=1 and gnt[i]=1; the requester holds req and addr stable until then.
REQ-017 Each cycle, gnt SHALL assert for at most one requester, and only for one with req=1.
REQ-018 Winner selection SHALL be round-robin, starting the search at pointer ptr and moving upward modulo N_REQ.
REQ-019 After a grant to requester i, ptr SHALL become (i+1) mod N_REQ, except while a burst lock holds (REQ-020).
REQ-020 Burst lock: while the last-granted requester L keeps req[L]=1, it SHALL be granted again and burst counter bcnt SHALL increment.
REQ-021 When bcnt reaches BURST_MAX and any other req is high, L SHALL lose priority for that cycle; the search starts at L+1 and bcnt resets to 1 for the new winner.
REQ-022 If L drops req or another requester wins, bcnt SHALL reload to 1 for the winner; with no request, bcnt and ptr SHALL hold.
REQ-023 State machine SHALL be IDLE (no owner) and OWNED (L valid): IDLE->OWNED on any grant; OWNED->IDLE on a cycle with no req; OWNED->OWNED on a grant, with L updated.
REQ-024 rom_addr SHALL equal the granted requester's address in the grant cycle and SHALL hold its previous value when nothing is granted.
REQ-025 Latency: a grant in cycle T SHALL produce rd_valid[i]=1 in cycle T+1 with rd_data=rom_data; one read per cycle, fully pipelined.
REQ-026 Out of range: if the granted addr >= DEPTH, the grant SHALL still complete, and in T+1 rd_valid[i]=1, rd_data=0 and rd_err=1.
REQ-027 rd_err SHALL be 0 whenever rd_valid is 0.
REQ-028 When no grant occurs in T, rd_valid SHALL be 0 in T+1 and rd_data SHALL be 0.
REQ-029 Tag and error flags SHALL be held in registers; rd_data is a combinational select of rom_data.

Reset
REQ-030 On Reset=1 at a clock edge: ptr=0, bcnt=0, state IDLE, rom_addr=0, and the in-flight tag and error registers cleared, so rd_valid=0 and rd_err=0 in the following cycle.
REQ-031 While Reset=1, gnt SHALL be 0; a read in flight when reset asserts SHALL be discarded and not returned.

Verification
REQ-032 The bench SHALL cover this case: after reset, req=4'b0001, addr0=100 -> gnt=0001 in T; rom_addr=100; rd_valid=0001 and rd_data=mem[100] in T+1.
REQ-033 The bench SHALL cover this case: req=4'b1111 held for 4 single-beat requests, each requester dropping req after its grant -> grants in order 0,1,2,3, one per cycle, with rd_valid tags matching one cycle later.
REQ-034 The bench SHALL cover this case: requester 2 holds req for 12 cycles and requester 0 requests from cycle 3 -> requester 2 gets 8 consecutive grants, then requester 0 is granted once, then requester 2 resumes.
REQ-035 The bench SHALL cover this case: addr1=80000 granted -> next cycle rd_valid=0010, rd_data=0, rd_err=1; addr1=79999 -> rd_err=0.
REQ-036 The bench SHALL cover this case: Reset asserted in the cycle after a grant -> no rd_valid is returned, ptr=0, and the first post-reset grant with req=1111 goes to requester 0.
REQ-037 The bench SHALL cover this case: req=0 for 5 cycles -> gnt=0, rd_valid=0, and rom_addr stable throughout.
